// File: rtl/dual_port_bram_be_pkg.sv
// Purpose: shared constants for dual_port_bram_be: read-during-write mode
//          encodings, init/ready FSM state encoding and a parameter-legality
//          helper used by the top-level elaboration check.
// Ports:   none (package).
package dual_port_bram_be_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  localparam int unsigned STATE_W = 1;
  localparam logic [STATE_W-1:0] ST_INIT  = 1'b0;
  localparam logic [STATE_W-1:0] ST_READY = 1'b1;

  // True when the width is a whole number of bytes, latency is 1 or 2 and
  // the read-during-write mode is one of the two known encodings.
  function automatic bit params_legal(input int unsigned data_width,
                                      input int unsigned read_latency,
                                      input int unsigned rdw_mode);
    return (data_width != 0) && ((data_width % 8) == 0) &&
           ((read_latency == 1) || (read_latency == 2)) &&
           (rdw_mode <= RDW_WRITE_FIRST);
  endfunction

endpackage

// File: rtl/dual_port_bram_be_bram_byte_lane.sv
// Purpose: one 8-bit, 2**ADDR_WIDTH-deep true dual-port storage lane.
//          Applies per-port byte writes with port A winning a same-address
//          write-write conflict, and returns the unregistered read byte
//          according to the read-during-write mode.
// Ports:   clk                   - write clock
//          we_a/addr_a/din_a     - port A write strobe (already qualified), address, data
//          rdata_a_c             - port A combinational read byte
//          we_b/addr_b/din_b     - port B write strobe, address, data
//          rdata_b_c             - port B combinational read byte
module bram_byte_lane
  import dual_port_bram_be_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [7:0]            din_a,
  output logic [7:0]            rdata_a_c,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [7:0]            din_b,
  output logic [7:0]            rdata_b_c
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  // Port A is written last so it overrides port B on the same address.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= din_b;
    if (we_a) mem[addr_a] <= din_a;
  end

  // Reads see the pre-edge array, so the other port's write is never forwarded;
  // write-first only merges this port's own byte.
  if (RDW_MODE == RDW_WRITE_FIRST) begin : g_write_first
    assign rdata_a_c = we_a ? din_a : mem[addr_a];
    assign rdata_b_c = we_b ? din_b : mem[addr_b];
  end else begin : g_read_first
    assign rdata_a_c = mem[addr_a];
    assign rdata_b_c = mem[addr_b];
  end

endmodule

// File: rtl/dual_port_bram_be.sv
// Purpose: true dual-port RAM with byte write enables, 1- or 2-cycle read
//          latency, selectable read-during-write mode, same-address
//          collision flag and optional zero-fill after reset.
// Ports:   i_clk, i_rst (async, active-high)
//          o_init_busy                      - zero-fill in progress, ports ignored
//          i_en_x/i_we_x/i_addr_x/i_din_x   - port x request (x = a, b)
//          o_dout_x/o_valid_x               - port x read data and one-pulse valid
//          o_collision                      - same-address conflict seen last cycle
module dual_port_bram_be
  import dual_port_bram_be_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned RDW_MODE      = 0,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  output logic                    o_init_busy,
  input  logic                    i_en_a,
  input  logic [DATA_WIDTH/8-1:0] i_we_a,
  input  logic [ADDR_WIDTH-1:0]   i_addr_a,
  input  logic [DATA_WIDTH-1:0]   i_din_a,
  output logic [DATA_WIDTH-1:0]   o_dout_a,
  output logic                    o_valid_a,
  input  logic                    i_en_b,
  input  logic [DATA_WIDTH/8-1:0] i_we_b,
  input  logic [ADDR_WIDTH-1:0]   i_addr_b,
  input  logic [DATA_WIDTH-1:0]   i_din_b,
  output logic [DATA_WIDTH-1:0]   o_dout_b,
  output logic                    o_valid_b,
  output logic                    o_collision
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam logic [STATE_W-1:0] ST_RESET = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;

  if (!params_legal(DATA_WIDTH, READ_LATENCY, RDW_MODE)) begin : g_param_check
    $error("dual_port_bram_be: illegal DATA_WIDTH/READ_LATENCY/RDW_MODE");
  end

  logic [STATE_W-1:0]    state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_nxt;
  logic                  init_busy_nxt;

  // Init/ready state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_RESET;
      init_cnt    <= '0;
      o_init_busy <= (INIT_ON_RESET != 0);
    end else begin
      state       <= state_nxt;
      init_cnt    <= init_cnt_nxt;
      o_init_busy <= init_busy_nxt;
    end
  end

  // Next-state: walk the whole array once, then stay in READY.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      ST_INIT: begin
        init_cnt_nxt = init_cnt + ADDR_WIDTH'(1);
        if (init_cnt == {ADDR_WIDTH{1'b1}}) state_nxt = ST_READY;
      end
      default: ;
    endcase
    init_busy_nxt = (state_nxt == ST_INIT);
  end

  // Qualify with reset so nothing touches the array while reset is held.
  logic init_c, acc_a_c, acc_b_c;
  logic [ADDR_WIDTH-1:0] addr_a_c;
  logic [DATA_WIDTH-1:0] rdata_a_c, rdata_b_c;

  assign init_c   = (state == ST_INIT)  & ~i_rst;
  assign acc_a_c  = (state == ST_READY) & ~i_rst & i_en_a;
  assign acc_b_c  = (state == ST_READY) & ~i_rst & i_en_b;
  assign addr_a_c = init_c ? init_cnt : i_addr_a;

  // Zero-fill borrows port A: all lanes written with 0 at the init counter.
  for (genvar k = 0; k < NB; k++) begin : g_lane
    logic       we_a_l, we_b_l;
    logic [7:0] din_a_l;

    assign we_a_l  = init_c | (acc_a_c & i_we_a[k]);
    assign din_a_l = init_c ? 8'h00 : i_din_a[8*k +: 8];
    assign we_b_l  = acc_b_c & i_we_b[k];

    bram_byte_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RDW_MODE   (RDW_MODE)
    ) u_lane (
      .clk       (i_clk),
      .we_a      (we_a_l),
      .addr_a    (addr_a_c),
      .din_a     (din_a_l),
      .rdata_a_c (rdata_a_c[8*k +: 8]),
      .we_b      (we_b_l),
      .addr_b    (i_addr_b),
      .din_b     (i_din_b[8*k +: 8]),
      .rdata_b_c (rdata_b_c[8*k +: 8])
    );
  end

  logic                  v1_a, v1_b;
  logic [DATA_WIDTH-1:0] d1_a, d1_b;

  // First output stage and collision flag; data holds when no access completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1_a        <= 1'b0;
      v1_b        <= 1'b0;
      d1_a        <= '0;
      d1_b        <= '0;
      o_collision <= 1'b0;
    end else begin
      v1_a        <= acc_a_c;
      v1_b        <= acc_b_c;
      if (acc_a_c) d1_a <= rdata_a_c;
      if (acc_b_c) d1_b <= rdata_b_c;
      o_collision <= acc_a_c & acc_b_c & (i_addr_a == i_addr_b) &
                     ((|i_we_a) | (|i_we_b));
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  v2_a, v2_b;
    logic [DATA_WIDTH-1:0] d2_a, d2_b;

    // Extra output register; fully pipelined, no stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        v2_a <= 1'b0;
        v2_b <= 1'b0;
        d2_a <= '0;
        d2_b <= '0;
      end else begin
        v2_a <= v1_a;
        v2_b <= v1_b;
        if (v1_a) d2_a <= d1_a;
        if (v1_b) d2_b <= d1_b;
      end
    end

    assign o_valid_a = v2_a;
    assign o_valid_b = v2_b;
    assign o_dout_a  = d2_a;
    assign o_dout_b  = d2_b;
  end else begin : g_lat1
    assign o_valid_a = v1_a;
    assign o_valid_b = v1_b;
    assign o_dout_a  = d1_a;
    assign o_dout_b  = d1_b;
  end

endmodule

// File: doc/dual_port_bram_be.md
# dual_port_bram_be

- True dual-port RAM with per-byte write enables and configurable read latency (1 or 2 cycles).
- Selectable same-port read-during-write mode, deterministic cross-port collision resolution, and an optional zero-fill sequence after reset.
- Used as the parametrised feature/weight buffer between the AXI-mapped host port (A) and the conv2d datapath (B).

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
- ADDR_WIDTH, 10, depth = 2**ADDR_WIDTH words
- READ_LATENCY, 1, 1 or 2 cycles from accepted access to o_valid
- RDW_MODE, 0, same-port read-during-write: 0 read-first (old data), 1 write-first (merged new data)
- INIT_ON_RESET, 1, 1 = zero-fill whole array after reset; 0 = contents undefined, ready immediately

Ports:
- i_clk  in  1  single clock, all logic rising-edge
- i_rst  in  1  asynchronous, active-high reset
- o_init_busy  out  1  high while zero-fill runs; ports ignored
- i_en_a  in  1  port A access request
- i_we_a  in  NB  port A byte write enables (bit k -> din[8k+7:8k])
- i_addr_a  in  ADDR_WIDTH  port A address
- i_din_a  in  DATA_WIDTH  port A write data
- o_dout_a  out  DATA_WIDTH  port A read data
- o_valid_a  out  1  o_dout_a valid, one pulse per accepted access
- i_en_b, i_we_b, i_addr_b, i_din_b, o_dout_b, o_valid_b: identical for port B
- o_collision  out  1  one-cycle pulse: same-address conflict detected

## Operation
- FSM states: INIT, READY.
- Reset entry:
  - INIT_ON_RESET=1 -> INIT with clear counter 0.
  - INIT_ON_RESET=0 -> READY.
- INIT:
  - Each cycle writes all-zero to address counter, all lanes; counter increments.
  - After address 2**ADDR_WIDTH-1 is written -> READY next cycle.
  - Takes exactly 2**ADDR_WIDTH cycles.
- Accepted access: i_en_x=1 and state READY. Requests during INIT are dropped; no valid pulse.
- Write: each lane k with i_we_x[k]=1 stores din byte k; other lanes keep old value.
- Every accepted access (read or write) produces exactly one o_valid_x pulse.
  - i_we_x=0: data is the stored word.
  - i_we_x!=0: RDW_MODE=0 gives the pre-write word; RDW_MODE=1 gives the merged word.
- Cross-port, same cycle, same address:
  - A reader always sees old data; the other port's write is not forwarded.
  - Both writing: lanes enabled on both ports take port A data; lanes enabled on one port take that port's data.
- o_collision: asserted 1 cycle after a cycle with both en high, equal addresses, and (|i_we_a | |i_we_b). Read-read never flags.
- o_dout_x holds its last value when no access completes.
- Reset mid-operation:
  - Outputs and pipeline clear immediately.
  - In-flight reads are lost.
  - Init restarts from address 0.
  - Array contents are not asynchronously reset.

## Timing
- Reset values: o_dout_a/b=0, o_valid_a/b=0, o_collision=0, o_init_busy=INIT_ON_RESET.
- o_init_busy falls on the same edge the FSM enters READY. The first accepted access is the cycle o_init_busy is low.
- READ_LATENCY=1: access at edge N -> o_dout/o_valid registered at edge N+1.
- READ_LATENCY=2: extra output register; data at edge N+2. Full throughput, one access per port per cycle, no stalls.
- A write is visible to any read accepted at edge N+1 or later.
- o_collision aligns with edge N+1 regardless of READ_LATENCY.

## Structure
- Shared package: RDW_READ_FIRST/RDW_WRITE_FIRST constants, FSM state encoding (INIT/READY), parameter-legality checks (DATA_WIDTH%8==0, READ_LATENCY in {1,2}) as elaboration assertions.
- Sub-module bram_byte_lane:
  - One 8-bit-wide, 2**ADDR_WIDTH-deep dual-port lane, instantiated NB times.
  - Handles per-port write, cross-port priority and RDW_MODE for its byte.
  - Top holds the init FSM/counter, the collision detector and the output/valid pipeline.

## Test plan
- Reset with INIT_ON_RESET=1, ADDR_WIDTH=4 -> o_init_busy high exactly 16 cycles; then port B reads addr 0..15 all return 0x00000000, each with one o_valid_b pulse.
- Port A writes 0xDEADBEEF to addr 5 with we=4'b1111, then we=4'b0010 with din 0x00001200 -> B read of addr 5 returns 0xDEAD12EF.
- Port A writes 0xAAAAAAAA to addr 3 holding 0x11111111 -> RDW_MODE=0 o_dout_a=0x11111111; RDW_MODE=1 o_dout_a=0xAAAAAAAA.
- Same cycle, addr 7: A writes 0x01020304 we=4'b0011, B writes 0xF0F0F0F0 we=4'b0110 -> o_collision pulses once; later read returns 0x00F00304.
- READ_LATENCY=2 with back-to-back reads on addresses 1,2,3 -> data on edges N+2..N+4 in order, o_valid continuous for 3 cycles.
- Assert i_rst mid-stream with 2 reads in flight -> o_valid drops immediately, no stale pulses; init restarts at 0.
